// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and counter sizing.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } reset_state_t;

    // Counters never need to reach n itself, so $clog2(n) bits suffice (at least one).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises the raw active-low button and accepts a level change only after it is stable.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES from pin change to pressed change; no backpressure.
module btn_debounce
    import reset_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic pressed
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        meta_d   = btn_n;
        sync_d   = meta_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser flops carry no reset so they can sit in a tight metastability-friendly pair.
    always_ff @(posedge clk) begin
        meta_q <= meta_d;
        sync_q <= sync_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pressed = ~stable_q;

endmodule

// File: rtl/reset_sequencer.sv
// Board reset controller: holds all domains in reset after any trigger, then releases them in order.
// Latency: registered outputs, bit 0 free HOLD_CYCLES after trigger drops, GAP_CYCLES per step; no backpressure.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int HOLD_CYCLES     = 255,
    parameter int GAP_CYCLES      = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            BTN_N,
    input  logic            PLL_LOCKED,
    output logic [N_CH-1:0] RST_OUT,
    output logic            READY
);

    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int GAP_W  = cnt_width(GAP_CYCLES);
    localparam int IDX_W  = cnt_width(N_CH);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CH - 1);

    logic              pll_meta_q, pll_meta_d;
    logic              pll_sync_q, pll_sync_d;
    logic              btn_pressed;
    logic              trigger;

    reset_state_t      state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [N_CH-1:0]   rst_out_q, rst_out_d;
    logic              ready_q, ready_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk     (CLK),
        .reset   (RESET),
        .btn_n   (BTN_N),
        .pressed (btn_pressed)
    );

    assign pll_meta_d = PLL_LOCKED;
    assign pll_sync_d = pll_meta_q;

    always_ff @(posedge CLK) begin
        pll_meta_q <= pll_meta_d;
        pll_sync_q <= pll_sync_d;
    end

    assign trigger = RESET | btn_pressed | ~pll_sync_q;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        if (trigger) begin
            state_d   = ASSERT;
            hold_d    = '0;
            gap_d     = '0;
            idx_d     = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
        end else begin
            unique case (state_q)
                ASSERT: begin
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                    if (hold_q == HOLD_LAST) begin
                        rst_out_d[0] = 1'b0;
                        gap_d        = '0;
                        if (N_CH == 1) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end else begin
                            // idx points at the next channel still held in reset
                            state_d = RELEASE;
                            idx_d   = IDX_W'(1);
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                RELEASE: begin
                    if (gap_q == GAP_LAST) begin
                        rst_out_d[idx_q] = 1'b0;
                        gap_d            = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                RUN: begin
                    rst_out_d = '0;
                    ready_d   = 1'b1;
                end
                default: begin
                    state_d = ASSERT;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ASSERT;
            hold_q    <= '0;
            gap_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
        end
    end

    assign RST_OUT = rst_out_q;
    assign READY   = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: 3-channel instance plus a single-channel instance on shared inputs.
module tb_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       btn_n;
    logic       pll_locked;
    logic [2:0] rst_out;
    logic       ready;
    logic [0:0] rst_out1;
    logic       ready1;

    int n_cmp = 0;
    int n_err = 0;

    reset_sequencer #(
        .N_CH(3), .HOLD_CYCLES(8), .GAP_CYCLES(4), .DEBOUNCE_CYCLES(5)
    ) dut (
        .CLK(clk), .RESET(reset), .BTN_N(btn_n), .PLL_LOCKED(pll_locked),
        .RST_OUT(rst_out), .READY(ready)
    );

    reset_sequencer #(
        .N_CH(1), .HOLD_CYCLES(8), .GAP_CYCLES(4), .DEBOUNCE_CYCLES(5)
    ) dut1 (
        .CLK(clk), .RESET(reset), .BTN_N(btn_n), .PLL_LOCKED(pll_locked),
        .RST_OUT(rst_out1), .READY(ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected {READY, RST_OUT} c edges into a release where bits fall at edges b0, b1, b2.
    function automatic logic [3:0] release_pat(input int c, input int b0, input int b1, input int b2);
        if (c < b0) return 4'b0111;
        if (c < b1) return 4'b0110;
        if (c < b2) return 4'b0100;
        return 4'b1000;
    endfunction

    task automatic test_reset;
        logic [3:0] exp;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if ({ready, rst_out} !== 4'b0111) begin
                n_err++;
                $display("FAIL reset_hold cyc %0d: got %b want 0111", i, {ready, rst_out});
            end
            n_cmp++;
            if ({ready1, rst_out1} !== 2'b01) begin
                n_err++;
                $display("FAIL reset_hold_1ch cyc %0d: got %b want 01", i, {ready1, rst_out1});
            end
        end
        reset = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            exp = release_pat(c, 8, 12, 16);
            n_cmp++;
            if ({ready, rst_out} !== exp) begin
                n_err++;
                $display("FAIL power_on cyc %0d: got %b want %b", c, {ready, rst_out}, exp);
            end
        end
    endtask

    task automatic test_button_glitch;
        btn_n = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 3) btn_n = 1'b1;
            n_cmp++;
            if ({ready, rst_out} !== 4'b1000) begin
                n_err++;
                $display("FAIL btn_glitch cyc %0d: got %b want 1000", c, {ready, rst_out});
            end
        end
    endtask

    task automatic test_held_button;
        logic [3:0] exp;
        btn_n = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            exp = (c < 8) ? 4'b1000 : 4'b0111;
            n_cmp++;
            if ({ready, rst_out} !== exp) begin
                n_err++;
                $display("FAIL btn_held cyc %0d: got %b want %b", c, {ready, rst_out}, exp);
            end
        end
        btn_n = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            tick();
            exp = release_pat(c, 15, 19, 23);
            n_cmp++;
            if ({ready, rst_out} !== exp) begin
                n_err++;
                $display("FAIL btn_release cyc %0d: got %b want %b", c, {ready, rst_out}, exp);
            end
        end
    endtask

    task automatic test_lock_loss;
        logic [3:0] exp;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) tick();
        n_cmp++;
        if ({ready, rst_out} !== 4'b0110) begin
            n_err++;
            $display("FAIL lock_pre: got %b want 0110", {ready, rst_out});
        end
        pll_locked = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            tick();
            if (c == 1) pll_locked = 1'b1;
            exp = (c < 3) ? 4'b0110 : release_pat(c, 11, 15, 19);
            n_cmp++;
            if ({ready, rst_out} !== exp) begin
                n_err++;
                $display("FAIL lock_loss cyc %0d: got %b want %b", c, {ready, rst_out}, exp);
            end
        end
    endtask

    task automatic test_retrigger_hold;
        logic [3:0] exp;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({ready, rst_out} !== 4'b0111) begin
            n_err++;
            $display("FAIL retrig_assert: got %b want 0111", {ready, rst_out});
        end
        for (int c = 1; c <= 22; c++) begin
            tick();
            if (c == 5) reset = 1'b1;
            if (c == 6) reset = 1'b0;
            exp = release_pat(c, 14, 18, 22);
            n_cmp++;
            if ({ready, rst_out} !== exp) begin
                n_err++;
                $display("FAIL retrig_hold cyc %0d: got %b want %b", c, {ready, rst_out}, exp);
            end
        end
    endtask

    task automatic test_single_channel;
        logic [1:0] exp;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            exp = (c < 8) ? 2'b01 : 2'b10;
            n_cmp++;
            if ({ready1, rst_out1} !== exp) begin
                n_err++;
                $display("FAIL single_ch cyc %0d: got %b want %b", c, {ready1, rst_out1}, exp);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        btn_n      = 1'b1;
        pll_locked = 1'b1;
        test_reset();
        test_button_glitch();
        test_held_button();
        test_lock_loss();
        test_retrigger_hold();
        test_single_channel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset controller for the board top level. It replaces the fixed 8-bit reset-stretch counter with a full reset sequence. It synchronises and debounces the raw push-button, combines it with PLL lock and the system reset, holds all reset outputs for a programmable time, and then releases `N_CH` reset domains in order with a programmable gap between them. Its outputs drive the per-domain resets of `mcpu` and peripherals, and a `READY` flag.

## Interface
- `N_CH`, 4: number of reset channels released in sequence (≥1).
- `HOLD_CYCLES`, 255: minimum cycles all channels stay asserted after the last trigger deasserts (≥1).
- `GAP_CYCLES`, 16: cycles between successive channel releases (≥1).
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles needed to accept a button level change (≥1).

- `CLK` in 1: single clock; all logic on its rising edge.
- `RESET` in 1: synchronous, active-high reset. It is also a sequence trigger.
- `BTN_N` in 1: raw asynchronous push-button, active-low (pressed = 0).
- `PLL_LOCKED` in 1: PLL lock, asynchronous. Synchronised internally; 0 is a trigger.
- `RST_OUT` out `N_CH`: active-high per-domain resets. Bit 0 is released first.
- `READY` out 1: 1 when all channels are released.

## Operation
- Reset values while `RESET`=1:
  - `RST_OUT` all ones, `READY`=0, state `ASSERT`.
  - Hold, gap and debounce counters at 0; channel index 0.
  - Debounced button state is "released".
  - Synchroniser flops are not reset.
- Synchronisers: `BTN_N` and `PLL_LOCKED` each pass through a 2-flop synchroniser, giving 2 cycles of latency.
- Debounce:
  - The counter increments while the synced level differs from the stable level. It clears whenever they match.
  - When the counter reaches `DEBOUNCE_CYCLES`-1 with the level still differing, the stable level takes the new value and the counter clears.
- Trigger = `RESET` | (stable button pressed) | ~(synced `PLL_LOCKED`). A held button or a lost lock keeps the trigger high continuously.
- State `ASSERT`:
  - `RST_OUT` all ones, `READY`=0.
  - The hold counter clears on any cycle the trigger is high. It increments on each cycle the trigger is low.
  - When the hold counter is at `HOLD_CYCLES`-1 and the trigger is low, the block clears `RST_OUT[0]`, moves to `RELEASE` (or `RUN` if `N_CH`=1) and clears the gap counter.
- State `RELEASE`:
  - The gap counter increments each cycle.
  - At `GAP_CYCLES`-1 the block clears the next `RST_OUT` bit, advances the channel index and clears the gap counter.
  - Releasing bit `N_CH`-1 moves to `RUN`.
- State `RUN`: `RST_OUT` all zeros, `READY`=1. The block stays here until a trigger.
- A trigger in any state asserts all `RST_OUT` bits and clears `READY` on the next edge. The state returns to `ASSERT` and the hold counter and channel index clear. A trigger mid-sequence restarts the sequence from channel 0.
- `RST_OUT` is monotonic during release: a bit never deasserts out of order, and never reasserts except via a trigger.
- Counter widths are `$clog2` of the respective parameter, minimum 1 bit. No wrap-around is reachable.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Call the first cycle on which the trigger is low T.
  - `RST_OUT[0]` falls at the edge ending cycle T+`HOLD_CYCLES`-1.
  - `RST_OUT[i]` falls `GAP_CYCLES` cycles after `RST_OUT[i-1]`.
  - `READY` rises on the same edge as `RST_OUT[N_CH-1]` falls.
- Button press to trigger: 2 (sync) + `DEBOUNCE_CYCLES` cycles. All resets assert on the following edge.
- `PLL_LOCKED` falling to `RST_OUT` asserted: 3 edges.

## Structure
- Package `reset_seq_pkg`: state typedef `reset_state_t` (`ASSERT`, `RELEASE`, `RUN`) and a width helper function.
- One sub-module, `btn_debounce`, which contains the 2-flop synchroniser and the debounce counter and outputs the stable pressed level.
- The `PLL_LOCKED` synchroniser is instantiated directly in `reset_sequencer`.

## Test plan
Parameters for all scenarios except the last: `N_CH`=3, `HOLD_CYCLES`=8, `GAP_CYCLES`=4, `DEBOUNCE_CYCLES`=5, `PLL_LOCKED`=1, `BTN_N`=1.

- **Power-on release:** `RESET`=1 for 3 cycles, then 0.
  - `RST_OUT`=111 throughout reset.
  - Bit 0 falls 8 cycles after `RESET` falls, bit 1 falls 4 cycles later, and bit 2 with `READY` 4 cycles after that.
- **Button glitch:** in `RUN`, `BTN_N` low for 3 cycles.
  - No change: `RST_OUT`=000, `READY`=1.
- **Held button:** in `RUN`, `BTN_N` low for 20 cycles, then high.
  - `RST_OUT`=111 and `READY`=0 starting 8 edges after `BTN_N` falls.
  - Bit 0 is released 2+5+8 cycles after `BTN_N` rises, then bits 1 and 2 follow at the 4-cycle gap.
- **Lock loss mid-release:** drop `PLL_LOCKED` for 1 cycle after `RST_OUT`=110.
  - `RST_OUT` returns to 111, and the sequence restarts with the full 8-cycle hold from channel 0.
- **Retrigger during hold:** pulse `RESET` on hold-count 5.
  - The hold restarts; bit 0 falls 8 cycles after the pulse ends.
- **Single channel:** `N_CH`=1.
  - `RST_OUT[0]` and `READY` change on the same edge, `HOLD_CYCLES` after reset.
